// File: rtl/test_card_pkg.sv
// Shared definitions for the colour-bar test card checker: band colours, band count and FSM states.
// Used by both builds of test_card_checker (TEST_CARD_CHECKER_FIRST_ERR_EN defined or not).
package test_card_pkg;

    localparam int BAND_COUNT = 8;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h00_00_00;
    localparam rgb_t RGB_BAND0 = 24'hFF_00_00;
    localparam rgb_t RGB_BAND1 = 24'hFF_FF_00;
    localparam rgb_t RGB_BAND2 = 24'h00_FF_00;
    localparam rgb_t RGB_BAND3 = 24'h00_FF_FF;
    localparam rgb_t RGB_BAND4 = 24'h00_00_FF;
    localparam rgb_t RGB_BAND5 = 24'hFF_00_FF;
    localparam rgb_t RGB_BAND6 = 24'h7F_7F_7F;
    localparam rgb_t RGB_BAND7 = 24'h3F_3F_3F;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_e;

    // Any band index past the last bar (overlong line) expects black.
    function automatic rgb_t band_rgb(input logic [3:0] band);
        case (band)
            4'd0:    return RGB_BAND0;
            4'd1:    return RGB_BAND1;
            4'd2:    return RGB_BAND2;
            4'd3:    return RGB_BAND3;
            4'd4:    return RGB_BAND4;
            4'd5:    return RGB_BAND5;
            4'd6:    return RGB_BAND6;
            4'd7:    return RGB_BAND7;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/test_card_band_tracker.sv
// Divider-free band tracking: column, in-band and band counters, line counter and de edge detection.
// Exposes the current line index only when TEST_CARD_CHECKER_FIRST_ERR_EN is defined.
module test_card_band_tracker
    import test_card_pkg::*;
#(
    parameter int H_RES = 640
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame,
    input  logic        i_de,
    output rgb_t        o_exp_rgb,
    output logic [15:0] o_col,
    output logic [15:0] o_lines,
    output logic [15:0] o_line_len,
    output logic        o_line_end
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    ,
    output logic [15:0] o_line_idx
`endif
);

    localparam int          HW       = H_RES >> 3;
    localparam logic [15:0] HW_LAST  = 16'(HW - 1);
    localparam logic [3:0]  BAND_OFF = 4'(BAND_COUNT);

    logic        de_q;
    logic        rise, fall;
    logic [15:0] col_q, col_d, col_cur;
    logic [15:0] inband_q, inband_d, inband_cur;
    logic [3:0]  band_q, band_d, band_cur;
    logic [15:0] line_q, line_d;

    assign rise = i_de && !de_q;
    assign fall = !i_de && de_q;

    // A rising edge of i_de puts the very same pixel at column 0 of band 0.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        col_cur    = rise ? '0 : col_q;
        inband_cur = rise ? '0 : inband_q;
        band_cur   = rise ? '0 : band_q;
        col_d      = col_q;
        inband_d   = inband_q;
        band_d     = band_q;
        if (i_de) begin
            col_d = col_cur + 16'd1;
            if (inband_cur == HW_LAST) begin
                inband_d = '0;
                band_d   = (band_cur == BAND_OFF) ? band_cur : band_cur + 4'd1;
            end else begin
                inband_d = inband_cur + 16'd1;
                band_d   = band_cur;
            end
        end
        line_d = i_frame ? '0 : (fall ? line_q + 16'd1 : line_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_q     <= 1'b0;
            col_q    <= '0;
            inband_q <= '0;
            band_q   <= '0;
            line_q   <= '0;
        end else begin
            de_q     <= i_de;
            col_q    <= col_d;
            inband_q <= inband_d;
            band_q   <= band_d;
            line_q   <= line_d;
        end
    end

    assign o_exp_rgb  = band_rgb(band_cur);
    assign o_col      = col_cur;
    assign o_lines    = line_q;
    assign o_line_len = col_q;
    assign o_line_end = fall;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    assign o_line_idx = i_frame ? '0 : line_q;
`endif

endmodule

// File: rtl/test_card_checker.sv
// Colour-bar test card checker: per-frame pass/fail verdict, saturating error count and frame count.
// Define TEST_CARD_CHECKER_FIRST_ERR_EN to add o_err_x/o_err_line/o_err_rgb first-pixel-error capture.
module test_card_checker
    import test_card_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int ERR_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame,
    input  logic             i_de,
    input  logic [15:0]      i_x,
    input  logic [7:0]       i_red,
    input  logic [7:0]       i_green,
    input  logic [7:0]       i_blue,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic [15:0]      o_frame_count
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    ,
    output logic [15:0]      o_err_x,
    output logic [15:0]      o_err_line,
    output logic [23:0]      o_err_rgb
`endif
);

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [1:0] b);
        logic [ERR_W:0] sum;
        sum = {1'b0, a} + {{(ERR_W-1){1'b0}}, b};
        return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    endfunction

    rgb_t        exp_rgb, rx_rgb;
    logic [15:0] col, lines, lines_total, line_len;
    logic        line_end;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    logic [15:0] line_idx;
`endif

    test_card_band_tracker #(.H_RES(H_RES)) u_tracker (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_frame    (i_frame),
        .i_de       (i_de),
        .o_exp_rgb  (exp_rgb),
        .o_col      (col),
        .o_lines    (lines),
        .o_line_len (line_len),
        .o_line_end (line_end)
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
        ,
        .o_line_idx (line_idx)
`endif
    );

    state_e state_q, state_d;
    logic   old_en, new_en, close;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_frame) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Line/frame errors belong to the frame being closed; a pixel alongside i_frame belongs to the new one.
    always_comb begin
        old_en = (state_q == ST_CHECK);
        close  = old_en && i_frame;
        new_en = old_en || i_frame;
    end

    logic       pix_err, line_err, frame_err;
    logic [1:0] s1_old_d, s1_old_q;
    logic       s1_new_d, s1_new_q, s1_close_q;

    always_comb begin
        rx_rgb      = {i_red, i_green, i_blue};
        pix_err     = i_de && ((rx_rgb != exp_rgb) || (i_x != col));
        line_err    = line_end && (line_len != 16'(H_RES));
        lines_total = lines + {15'd0, line_end};
        frame_err   = (lines_total != 16'(V_RES));
        s1_old_d    = {1'b0, old_en && line_err} + {1'b0, close && frame_err};
        s1_new_d    = new_en && pix_err;
    end

    logic [ERR_W-1:0] work_q, work_d, s2_err_q, s2_err_d;
    logic             s2_done_q;

    always_comb begin
        work_d   = work_q;
        s2_err_d = s2_err_q;
        if (s1_close_q) begin
            s2_err_d = sat_add(work_q, s1_old_q);
            work_d   = {{(ERR_W-1){1'b0}}, s1_new_q};
        end else begin
            work_d = sat_add(work_q, s1_old_q + {1'b0, s1_new_q});
        end
    end

    logic             done_q, pass_q;
    logic [ERR_W-1:0] err_q;
    logic [15:0]      frame_cnt_q;

    // NOTE: every register, pipeline included, is reset so a mid-frame reset discards all progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_old_q    <= '0;
            s1_new_q    <= 1'b0;
            s1_close_q  <= 1'b0;
            work_q      <= '0;
            s2_err_q    <= '0;
            s2_done_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            s1_old_q   <= s1_old_d;
            s1_new_q   <= s1_new_d;
            s1_close_q <= close;
            work_q     <= work_d;
            s2_err_q   <= s2_err_d;
            s2_done_q  <= s1_close_q;
            done_q     <= s2_done_q;
            if (s2_done_q) begin
                pass_q      <= (s2_err_q == '0);
                err_q       <= s2_err_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign o_done        = done_q;
    assign o_pass        = pass_q;
    assign o_err_count   = err_q;
    assign o_frame_count = frame_cnt_q;

`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    logic [15:0] s1_x_q, s1_line_q, fe_x_q, fe_x_d, fe_line_q, fe_line_d;
    logic [15:0] s2_x_q, s2_x_d, s2_line_q, s2_line_d, err_x_q, err_line_q;
    rgb_t        s1_rgb_q, fe_rgb_q, fe_rgb_d, s2_rgb_q, s2_rgb_d, err_rgb_q;
    logic        fe_valid_q, fe_valid_d;

    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_x_d     = fe_x_q;
        fe_line_d  = fe_line_q;
        fe_rgb_d   = fe_rgb_q;
        s2_x_d     = s2_x_q;
        s2_line_d  = s2_line_q;
        s2_rgb_d   = s2_rgb_q;
        if (s1_close_q) begin
            s2_x_d     = fe_valid_q ? fe_x_q    : '0;
            s2_line_d  = fe_valid_q ? fe_line_q : '0;
            s2_rgb_d   = fe_valid_q ? fe_rgb_q  : '0;
            fe_valid_d = s1_new_q;
            fe_x_d     = s1_x_q;
            fe_line_d  = s1_line_q;
            fe_rgb_d   = s1_rgb_q;
        end else if (s1_new_q && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_x_d     = s1_x_q;
            fe_line_d  = s1_line_q;
            fe_rgb_d   = s1_rgb_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_x_q     <= '0;
            s1_line_q  <= '0;
            s1_rgb_q   <= '0;
            fe_valid_q <= 1'b0;
            fe_x_q     <= '0;
            fe_line_q  <= '0;
            fe_rgb_q   <= '0;
            s2_x_q     <= '0;
            s2_line_q  <= '0;
            s2_rgb_q   <= '0;
            err_x_q    <= '0;
            err_line_q <= '0;
            err_rgb_q  <= '0;
        end else begin
            s1_x_q     <= i_x;
            s1_line_q  <= line_idx;
            s1_rgb_q   <= rx_rgb;
            fe_valid_q <= fe_valid_d;
            fe_x_q     <= fe_x_d;
            fe_line_q  <= fe_line_d;
            fe_rgb_q   <= fe_rgb_d;
            s2_x_q     <= s2_x_d;
            s2_line_q  <= s2_line_d;
            s2_rgb_q   <= s2_rgb_d;
            if (s2_done_q) begin
                err_x_q    <= s2_x_q;
                err_line_q <= s2_line_q;
                err_rgb_q  <= s2_rgb_q;
            end
        end
    end

    assign o_err_x    = err_x_q;
    assign o_err_line = err_line_q;
    assign o_err_rgb  = err_rgb_q;
`endif

endmodule

// File: tb/tb_test_card_checker.sv
// Self-checking bench for test_card_checker on a reduced 64x8 card with an 8-bit error counter.
// Also checks the first-error outputs when TEST_CARD_CHECKER_FIRST_ERR_EN is defined.
module tb_test_card_checker;

    localparam int H_RES   = 64;
    localparam int V_RES   = 8;
    localparam int ERR_W   = 8;
    localparam int HW      = H_RES / 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame = 1'b0;
    logic             de = 1'b0;
    logic [15:0]      x = '0;
    logic [7:0]       r = '0, g = '0, b = '0;
    logic             o_done, o_pass;
    logic [ERR_W-1:0] o_err_count;
    logic [15:0]      o_frame_count;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
    logic [15:0]      o_err_x, o_err_line;
    logic [23:0]      o_err_rgb;
`endif

    always #5 clk = ~clk;

    test_card_checker #(.H_RES(H_RES), .V_RES(V_RES), .ERR_W(ERR_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame       (frame),
        .i_de          (de),
        .i_x           (x),
        .i_red         (r),
        .i_green       (g),
        .i_blue        (b),
        .o_done        (o_done),
        .o_pass        (o_pass),
        .o_err_count   (o_err_count),
        .o_frame_count (o_frame_count)
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
        ,
        .o_err_x       (o_err_x),
        .o_err_line    (o_err_line),
        .o_err_rgb     (o_err_rgb)
`endif
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    typedef struct {
        int due;
        int err;
        int fcount;
        int ex;
        int ey;
        int ergb;
    } rep_t;
    rep_t pend[$];

    // Reference model: frame-level bookkeeping straight from the checking rules.
    bit m_active, m_de_prev, m_fe_valid;
    int m_err, m_lines, m_col, m_frames, m_fe_x, m_fe_y, m_fe_rgb;

    function automatic int ref_rgb(input int xx);
        case (xx / HW)
            0: return 32'hFF0000;
            1: return 32'hFFFF00;
            2: return 32'h00FF00;
            3: return 32'h00FFFF;
            4: return 32'h0000FF;
            5: return 32'hFF00FF;
            6: return 32'h7F7F7F;
            7: return 32'h3F3F3F;
            default: return 0;
        endcase
    endfunction

    task automatic drive_cycle(input bit f, input bit d, input int xx, input int rgb);
        bit   exp_done;
        int   pe;
        rep_t rp;
        @(negedge clk);
        exp_done = (pend.size() > 0) && (pend[0].due == cyc);
        n_total++;
        if (o_done !== exp_done) $display("FAIL done_timing cyc=%0d got=%b exp=%b", cyc, o_done, exp_done);
        else n_pass++;
        if (exp_done) begin
            rp = pend.pop_front();
            n_total++;
            if (o_err_count !== ERR_W'(rp.err)) $display("FAIL err_count cyc=%0d got=%0d exp=%0d", cyc, o_err_count, rp.err);
            else n_pass++;
            n_total++;
            if (o_pass !== (rp.err == 0)) $display("FAIL pass cyc=%0d got=%b exp=%b", cyc, o_pass, rp.err == 0);
            else n_pass++;
            n_total++;
            if (o_frame_count !== 16'(rp.fcount)) $display("FAIL frame_count cyc=%0d got=%0d exp=%0d", cyc, o_frame_count, rp.fcount);
            else n_pass++;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
            n_total++;
            if (o_err_x !== 16'(rp.ex) || o_err_line !== 16'(rp.ey) || o_err_rgb !== 24'(rp.ergb))
                $display("FAIL first_err cyc=%0d got=%0d/%0d/%06h exp=%0d/%0d/%06h",
                         cyc, o_err_x, o_err_line, o_err_rgb, rp.ex, rp.ey, rp.ergb);
            else n_pass++;
`endif
        end
        if (!d && m_de_prev) begin
            if (m_active && m_col != H_RES) m_err++;
            m_lines++;
        end
        if (d && !m_de_prev) m_col = 0;
        if (f) begin
            if (m_active) begin
                pe        = m_err + ((m_lines != V_RES) ? 1 : 0);
                m_frames++;
                rp.due    = cyc + 3;
                rp.err    = (pe > ERR_MAX) ? ERR_MAX : pe;
                rp.fcount = m_frames % 65536;
                rp.ex     = m_fe_valid ? m_fe_x : 0;
                rp.ey     = m_fe_valid ? m_fe_y : 0;
                rp.ergb   = m_fe_valid ? m_fe_rgb : 0;
                pend.push_back(rp);
            end
            m_active   = 1'b1;
            m_err      = 0;
            m_lines    = 0;
            m_fe_valid = 1'b0;
        end
        if (d) begin
            if (m_active && (rgb != ref_rgb(xx) || xx != m_col)) begin
                m_err++;
                if (!m_fe_valid) begin
                    m_fe_valid = 1'b1;
                    m_fe_x     = xx;
                    m_fe_y     = m_lines;
                    m_fe_rgb   = rgb;
                end
            end
            m_col++;
        end
        m_de_prev = d;
        frame     = f;
        de        = d;
        x         = 16'(xx);
        {r, g, b} = 24'(rgb);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame = 1'b0;
        de    = 1'b0;
        x     = '0;
        {r, g, b} = '0;
        pend.delete();
        m_active = 1'b0; m_de_prev = 1'b0; m_fe_valid = 1'b0;
        m_err = 0; m_lines = 0; m_col = 0; m_frames = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_line(input int len, input int err_rate, input bit black,
                             input int fx, input bit fhit, input bit merge);
        int xx, rgb;
        for (int p = 0; p < len; p++) begin
            xx  = p;
            rgb = black ? 0 : ref_rgb(p);
            if (fhit && p == fx) rgb = 0;
            if (err_rate > 0 && int'($urandom_range(999)) < err_rate) rgb ^= 1 << int'($urandom_range(23));
            if (err_rate > 0 && int'($urandom_range(999)) < err_rate / 2) xx = p + 1;
            drive_cycle(merge && p == 0, 1'b1, xx, rgb);
        end
        repeat (int'($urandom_range(2, 5))) drive_cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_frame(input int n_lines, input int short_line, input int err_rate,
                              input bit black, input int fx, input int fl, input bit merge);
        if (!merge) begin
            drive_cycle(1'b1, 1'b0, 0, 0);
            repeat (int'($urandom_range(3, 6))) drive_cycle(1'b0, 1'b0, 0, 0);
        end
        for (int l = 0; l < n_lines; l++)
            send_line((l == short_line) ? H_RES - 1 : H_RES, err_rate, black, fx, l == fl, merge && l == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++;
        if (o_done !== 1'b0 || o_pass !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", o_done, o_pass);
        else n_pass++;
        n_total++;
        if (o_err_count !== '0) $display("FAIL reset_err_count got=%0d exp=0", o_err_count);
        else n_pass++;
        n_total++;
        if (o_frame_count !== '0) $display("FAIL reset_frame_count got=%0d exp=0", o_frame_count);
        else n_pass++;
`ifdef TEST_CARD_CHECKER_FIRST_ERR_EN
        n_total++;
        if (o_err_x !== '0 || o_err_line !== '0 || o_err_rgb !== '0)
            $display("FAIL reset_first_err got=%0d/%0d/%06h exp=0/0/000000", o_err_x, o_err_line, o_err_rgb);
        else n_pass++;
`endif
    endtask

    task automatic test_ideal();
        send_frame(V_RES, -1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_forced_pixel();
        send_frame(V_RES, -1, 0, 1'b0, 13, 3, 1'b0);
    endtask

    task automatic test_short_line();
        send_frame(V_RES, 5, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_all_black();
        send_frame(V_RES, -1, 0, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_random_errors();
        for (int i = 0; i < 3; i++) send_frame(V_RES, -1, 15, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_merged_pulse();
        send_frame(V_RES, -1, 0, 1'b0, -1, -1, 1'b1);
    endtask

    task automatic test_short_frame();
        drive_cycle(1'b1, 1'b0, 0, 0);
        drive_cycle(1'b1, 1'b0, 0, 0);
        drive_cycle(1'b0, 1'b0, 0, 0);
        drive_cycle(1'b1, 1'b0, 0, 0);
        idle(3);
        send_frame(V_RES, -1, 0, 1'b0, -1, -1, 1'b0);
        drive_cycle(1'b1, 1'b0, 0, 0);
        idle(6);
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_frame(2, -1, 0, 1'b0, -1, -1, 1'b0);
        for (int p = 0; p < 10; p++) drive_cycle(1'b0, 1'b1, p, ref_rgb(p));
        do_reset();
        idle(2);
        send_frame(V_RES, -1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_frame(V_RES, -1, 0, 1'b0, -1, -1, 1'b0);
        send_frame(V_RES, -1, 0, 1'b0, -1, -1, 1'b0);
        drive_cycle(1'b1, 1'b0, 0, 0);
        idle(6);
        n_total++;
        if (pend.size() != 0) $display("FAIL undelivered_reports got=%0d exp=0", pend.size());
        else n_pass++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal();
        test_forced_pixel();
        test_short_line();
        test_all_black();
        test_random_errors();
        test_merged_pulse();
        test_short_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
